flush_redirect_ctrl: RTL and testbench

// Sequences the pipeline flush/refetch raised at writeback (exception, ertn, refetch).

---
 rtl/flush_redirect_ctrl_pkg.sv | 30 +++
 rtl/flush_redirect_ctrl_inst_inflight_cnt.sv | 31 +++
 rtl/flush_redirect_ctrl.sv | 128 ++++++++++++
 tb/tb_flush_redirect_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/flush_redirect_ctrl_pkg.sv
// Shared encodings and defaults for the WB flush / IF redirect controller.
// Optional feature macro used by the controller: FLUSH_CTRL_FAST_REDIR_EN.
package flush_redirect_ctrl_pkg;

  localparam int FLUSH_MAX_OUTSTANDING = 2;
  localparam int FLUSH_CNT_W           = $clog2(FLUSH_MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    FLUSH_ST_IDLE  = 2'd0,
    FLUSH_ST_DRAIN = 2'd1,
    FLUSH_ST_REDIR = 2'd2
  } flush_st_e;

  // Exception beats ertn, ertn beats refetch.
  function automatic logic [31:0] sel_target(
    input logic        wb_exc,
    input logic        ertn_flush,
    input logic [31:0] ex_entry,
    input logic [31:0] ertn_era,
    input logic [31:0] refetch_pc
  );
    if (wb_exc)
      return ex_entry;
    else if (ertn_flush)
      return ertn_era;
    else
      return refetch_pc;
  endfunction

endpackage

// File: rtl/flush_redirect_ctrl_inst_inflight_cnt.sv
// Up/down count of instruction requests accepted but not yet answered.
module inst_inflight_cnt
  import flush_redirect_ctrl_pkg::*;
#(
  parameter int MAX_OUTSTANDING = FLUSH_MAX_OUTSTANDING,
  parameter int CNT_W           = FLUSH_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt
);

  // Count up on request, down on response; simultaneous events cancel.
  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (inc && !dec)
      cnt <= cnt + 1'b1;
    else if (dec && !inc)
      cnt <= cnt - 1'b1;
  end

  // Bus protocol checks: never more than MAX_OUTSTANDING, never a response with nothing pending.
  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(inc && !dec && cnt == CNT_W'(MAX_OUTSTANDING)));
  a_no_underflow : assert property (@(posedge clk) disable iff (reset)
    !(dec && !inc && cnt == '0));

endmodule

// File: rtl/flush_redirect_ctrl.sv
// Pipeline flush / refetch sequencer between WB+CSR and the IF instruction request port.
// Build option: define FLUSH_CTRL_FAST_REDIR_EN to let an event with nothing stale in flight
// redirect IF in the same cycle instead of passing through DRAIN.
//
// state | meaning
// IDLE  | normal fetch, watching WB for flush events
// DRAIN | fetch held; responses to pre-flush requests are dropped until stale_cnt hits 0
// REDIR | fetch held; redirect_pc offered to IF until redirect_ready
module flush_redirect_ctrl
  import flush_redirect_ctrl_pkg::*;
#(
  parameter int MAX_OUTSTANDING = FLUSH_MAX_OUTSTANDING,
  parameter int CNT_W           = FLUSH_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_exc,
  input  logic        ertn_flush,
  input  logic        refetch_flush,
  input  logic [31:0] ex_entry,
  input  logic [31:0] ertn_era,
  input  logic [31:0] refetch_pc,
  input  logic        inst_req_fire,
  input  logic        inst_resp_fire,
  input  logic        redirect_ready,
  output logic        flush,
  output logic        fetch_hold,
  output logic        discard_resp,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  logic             ev;
  logic [31:0]      target;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] stale_calc;
  logic [CNT_W-1:0] stale_q;
  logic [CNT_W-1:0] stale_d;
  logic [31:0]      pc_q;
  flush_st_e        state_q;
  flush_st_e        state_d;

  inst_inflight_cnt #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .CNT_W          (CNT_W)
  ) u_inflight (
    .clk  (clk),
    .reset(reset),
    .inc  (inst_req_fire),
    .dec  (inst_resp_fire),
    .cnt  (inflight)
  );

  assign ev     = wb_exc | ertn_flush | refetch_flush;
  assign flush  = ev;
  assign target = sel_target(wb_exc, ertn_flush, ex_entry, ertn_era, refetch_pc);

  // A response landing in the event cycle belongs to an old request and is consumed here,
  // so it is not counted as stale; a request accepted in the event cycle is.
  assign stale_calc = inflight + CNT_W'(inst_req_fire) - CNT_W'(inst_resp_fire);

  // State, stale down-counter and latched redirect target.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FLUSH_ST_IDLE;
      stale_q <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      stale_q <= stale_d;
      if (ev)
        pc_q <= target;
    end
  end

  // Next state, stale count and IF-facing outputs.
  always_comb begin
    state_d        = state_q;
    stale_d        = stale_q;
    fetch_hold     = 1'b0;
    redirect_valid = 1'b0;
    discard_resp   = 1'b0;
    redirect_pc    = pc_q;
    unique case (state_q)
      FLUSH_ST_IDLE: begin
        if (ev) begin
          stale_d = stale_calc;
`ifdef FLUSH_CTRL_FAST_REDIR_EN
          if (stale_calc == '0) begin
            redirect_valid = 1'b1;
            redirect_pc    = target;
            state_d        = redirect_ready ? FLUSH_ST_IDLE : FLUSH_ST_REDIR;
          end else begin
            state_d = FLUSH_ST_DRAIN;
          end
`else
          state_d = FLUSH_ST_DRAIN;
`endif
        end
      end
      FLUSH_ST_DRAIN: begin
        fetch_hold   = 1'b1;
        discard_resp = inst_resp_fire && (stale_q != '0);
        if (discard_resp)
          stale_d = stale_q - 1'b1;
        // Leave as soon as the last stale response has been eaten; a new event restarts the drain.
        if (ev)
          state_d = FLUSH_ST_DRAIN;
        else if (stale_d == '0)
          state_d = FLUSH_ST_REDIR;
      end
      FLUSH_ST_REDIR: begin
        fetch_hold     = 1'b1;
        redirect_valid = 1'b1;
        if (ev)
          state_d = FLUSH_ST_DRAIN;
        else if (redirect_ready)
          state_d = FLUSH_ST_IDLE;
      end
      default: state_d = FLUSH_ST_IDLE;
    endcase
  end

  // IF is told to stop issuing while draining, so a request here is a protocol violation.
  a_no_req_in_drain : assert property (@(posedge clk) disable iff (reset)
    !(state_q == FLUSH_ST_DRAIN && inst_req_fire));

endmodule

// File: tb/tb_flush_redirect_ctrl.sv
// Directed bench for flush_redirect_ctrl (follows FLUSH_CTRL_FAST_REDIR_EN when defined).
module tb_flush_redirect_ctrl;
  import flush_redirect_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_exc, ertn_flush, refetch_flush;
  logic [31:0] ex_entry, ertn_era, refetch_pc;
  logic        inst_req_fire, inst_resp_fire, redirect_ready;
  logic        flush, fetch_hold, discard_resp, redirect_valid;
  logic [31:0] redirect_pc;

  int vectors     = 0;
  int miscompares = 0;

  flush_redirect_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .wb_exc        (wb_exc),
    .ertn_flush    (ertn_flush),
    .refetch_flush (refetch_flush),
    .ex_entry      (ex_entry),
    .ertn_era      (ertn_era),
    .refetch_pc    (refetch_pc),
    .inst_req_fire (inst_req_fire),
    .inst_resp_fire(inst_resp_fire),
    .redirect_ready(redirect_ready),
    .flush         (flush),
    .fetch_hold    (fetch_hold),
    .discard_resp  (discard_resp),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; pulses default low for the new cycle.
  task automatic nxt();
    @(posedge clk);
    #1;
    wb_exc         = 1'b0;
    ertn_flush     = 1'b0;
    refetch_flush  = 1'b0;
    inst_req_fire  = 1'b0;
    inst_resp_fire = 1'b0;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    reset          = 1'b1;
    wb_exc         = 1'b0;
    ertn_flush     = 1'b0;
    refetch_flush  = 1'b0;
    ex_entry       = 32'h0;
    ertn_era       = 32'h0;
    refetch_pc     = 32'h0;
    inst_req_fire  = 1'b0;
    inst_resp_fire = 1'b0;
    redirect_ready = 1'b0;

    // 1. reset held 3 cycles
    repeat (3) nxt();
    mid();
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_hold", 32'(fetch_hold), 32'd0);
    chk("rst_discard", 32'(discard_resp), 32'd0);
    chk("rst_rvalid", 32'(redirect_valid), 32'd0);
    chk("rst_pc", redirect_pc, 32'h0);
    chk("rst_state", 32'(dut.state_q), 32'(FLUSH_ST_IDLE));
    nxt();
    reset = 1'b0;

    // 2. exception with nothing in flight
    wb_exc   = 1'b1;
    ex_entry = 32'h1C00_8000;
`ifdef FLUSH_CTRL_FAST_REDIR_EN
    redirect_ready = 1'b1;
    mid();
    chk("t2_flush", 32'(flush), 32'd1);
    chk("t2_fast_rvalid", 32'(redirect_valid), 32'd1);
    chk("t2_fast_pc", redirect_pc, 32'h1C00_8000);
    nxt();
    mid();
    chk("t2_fast_idle_rvalid", 32'(redirect_valid), 32'd0);
    chk("t2_fast_idle_hold", 32'(fetch_hold), 32'd0);
`else
    mid();
    chk("t2_flush", 32'(flush), 32'd1);
    chk("t2_rvalid_c0", 32'(redirect_valid), 32'd0);
    nxt();
    mid();
    chk("t2_hold_c1", 32'(fetch_hold), 32'd1);
    chk("t2_rvalid_c1", 32'(redirect_valid), 32'd0);
    chk("t2_flush_c1", 32'(flush), 32'd0);
    nxt();
    redirect_ready = 1'b1;
    mid();
    chk("t2_rvalid_c2", 32'(redirect_valid), 32'd1);
    chk("t2_pc_c2", redirect_pc, 32'h1C00_8000);
    nxt();
    mid();
    chk("t2_idle_hold", 32'(fetch_hold), 32'd0);
    chk("t2_idle_rvalid", 32'(redirect_valid), 32'd0);
`endif
    redirect_ready = 1'b0;

    // 3. two requests outstanding, then ertn
    inst_req_fire = 1'b1;
    nxt();
    inst_req_fire = 1'b1;
    nxt();
    ertn_flush = 1'b1;
    ertn_era   = 32'h1C00_0104;
    mid();
    chk("t3_flush", 32'(flush), 32'd1);
    nxt();
    mid();
    chk("t3_hold", 32'(fetch_hold), 32'd1);
    chk("t3_rvalid_wait", 32'(redirect_valid), 32'd0);
    nxt();
    inst_resp_fire = 1'b1;
    mid();
    chk("t3_discard1", 32'(discard_resp), 32'd1);
    chk("t3_rvalid_mid", 32'(redirect_valid), 32'd0);
    nxt();
    inst_resp_fire = 1'b1;
    mid();
    chk("t3_discard2", 32'(discard_resp), 32'd1);
    nxt();
    redirect_ready = 1'b1;
    mid();
    chk("t3_rvalid", 32'(redirect_valid), 32'd1);
    chk("t3_pc", redirect_pc, 32'h1C00_0104);
    nxt();
    redirect_ready = 1'b0;
    mid();
    chk("t3_idle_hold", 32'(fetch_hold), 32'd0);

    // 4. exc + ertn together, req and resp in the event cycle with one in flight
    inst_req_fire = 1'b1;
    nxt();
    wb_exc         = 1'b1;
    ertn_flush     = 1'b1;
    ex_entry       = 32'h1C00_A000;
    ertn_era       = 32'h1C00_0104;
    inst_req_fire  = 1'b1;
    inst_resp_fire = 1'b1;
    mid();
    chk("t4_flush", 32'(flush), 32'd1);
    chk("t4_ev_discard", 32'(discard_resp), 32'd0);
    chk("t4_stale_cnt", 32'(dut.stale_d), 32'd1);
    nxt();
    mid();
    chk("t4_hold", 32'(fetch_hold), 32'd1);
    chk("t4_rvalid_wait", 32'(redirect_valid), 32'd0);
    nxt();
    inst_resp_fire = 1'b1;
    mid();
    chk("t4_discard", 32'(discard_resp), 32'd1);
    nxt();
    redirect_ready = 1'b1;
    mid();
    chk("t4_rvalid", 32'(redirect_valid), 32'd1);
    chk("t4_pc", redirect_pc, 32'h1C00_A000);
    nxt();
    redirect_ready = 1'b0;
    inst_req_fire  = 1'b1;
    nxt();
    inst_resp_fire = 1'b1;
    mid();
    chk("t4_no_second_discard", 32'(discard_resp), 32'd0);
    nxt();

    // 5. REDIR stalled 4 cycles, then refetch re-targets
    wb_exc   = 1'b1;
    ex_entry = 32'h1C00_8000;
    nxt();
    begin
      int budget = 4;
      mid();
      while (!redirect_valid && budget > 0) begin
        nxt();
        mid();
        budget--;
      end
      chk("t5_reach_redir", 32'(redirect_valid), 32'd1);
    end
    repeat (3) begin
      nxt();
      mid();
    end
    chk("t5_still_valid", 32'(redirect_valid), 32'd1);
    chk("t5_old_pc", redirect_pc, 32'h1C00_8000);
    nxt();
    refetch_flush = 1'b1;
    refetch_pc    = 32'h1C00_0200;
    mid();
    chk("t5_flush", 32'(flush), 32'd1);
    nxt();
    mid();
    chk("t5_drop", 32'(redirect_valid), 32'd0);
    chk("t5_drop_hold", 32'(fetch_hold), 32'd1);
    nxt();
    redirect_ready = 1'b1;
    mid();
    chk("t5_return", 32'(redirect_valid), 32'd1);
    chk("t5_new_pc", redirect_pc, 32'h1C00_0200);
    nxt();
    redirect_ready = 1'b0;

    // 6. reset in DRAIN with two stale responses pending
    inst_req_fire = 1'b1;
    nxt();
    inst_req_fire = 1'b1;
    nxt();
    wb_exc   = 1'b1;
    ex_entry = 32'h1C00_C000;
    nxt();
    mid();
    chk("t6_in_drain", 32'(fetch_hold), 32'd1);
    nxt();
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    mid();
    chk("t6_state", 32'(dut.state_q), 32'(FLUSH_ST_IDLE));
    chk("t6_hold", 32'(fetch_hold), 32'd0);
    chk("t6_pc", redirect_pc, 32'h0);
    inst_req_fire = 1'b1;
    nxt();
    inst_resp_fire = 1'b1;
    mid();
    chk("t6_no_discard", 32'(discard_resp), 32'd0);
    nxt();
    nxt();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
